mul_div_unit: RTL and testbench

- Multi-cycle signed multiply/divide engine beside the datapath ALU.
- Operand A comes from Y; operand B comes from the bus.
- The 64-bit result is loaded into Z: high half to ZHI, low half to ZLO.
- The control sequencer holds in its current T-step on `start`, then advances on `done`.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 65 ++++++
 rtl/mul_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared word width, multiply/divide op codes and sequencer states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int WORD_W = 32;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module  : muldiv_step
// Brief   : One combinational iteration: Booth add/sub + arithmetic shift
//           (MUL) or non-restoring shift + add/sub (DIV).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             i_op,
   input  logic [WIDTH:0]   i_acc,
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_q_1,
   input  logic [WIDTH:0]   i_m,
   output logic [WIDTH:0]   o_acc,
   output logic [WIDTH-1:0] o_q,
   output logic             o_q_1
);

   logic [WIDTH:0] w_base;
   logic [WIDTH:0] w_addend;
   logic [WIDTH:0] w_sum;
   logic           w_use;
   logic           w_sub;

   always_comb begin
      w_base   = i_acc;
      w_use    = 1'b0;
      w_sub    = 1'b0;
      w_addend = '0;
      w_sum    = '0;
      o_acc    = '0;
      o_q      = '0;
      o_q_1    = 1'b0;

      if (i_op == OP_MUL) begin
         // Booth pair {q0, q-1}: 01 adds M, 10 subtracts M
         w_use  = (i_q[0] != i_q_1);
         w_sub  = i_q[0];
      end else begin
         w_base = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
         w_use  = 1'b1;
         w_sub  = ~i_acc[WIDTH];
      end

      w_addend = w_use ? (w_sub ? ~i_m : i_m) : '0;
      w_sum    = w_base + w_addend + {{WIDTH{1'b0}}, (w_use & w_sub)};

      if (i_op == OP_MUL) begin
         o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
         o_q   = {w_sum[0], i_q[WIDTH-1:1]};
         o_q_1 = i_q[0];
      end else begin
         o_acc = w_sum;
         o_q   = {i_q[WIDTH-2:0], ~w_sum[WIDTH]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module  : mul_div_unit
// Brief   : Multi-cycle signed multiply/divide; WIDTH iterations then a
//           correction step. Optional MULDIV_UNSIGNED_EN adds unsigned_op.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             op,
`ifdef MULDIV_UNSIGNED_EN
   input  logic             unsigned_op,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] z_hi,
   output logic [WIDTH-1:0] z_lo
);

   localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   muldiv_state_t      r_state;
   muldiv_state_t      w_state_nxt;
   logic [c_CNT_W-1:0] r_count;
   logic               r_op;
   logic               r_uns;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH:0]     r_acc;
   logic [WIDTH-1:0]   r_q;
   logic               r_q_1;
   logic [WIDTH:0]     r_m;
   logic [WIDTH-1:0]   r_z_hi;
   logic [WIDTH-1:0]   r_z_lo;
   logic               r_dbz;

   logic               w_in_uns;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_step_acc;
   logic [WIDTH-1:0]   w_step_q;
   logic               w_step_q_1;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;
   logic               w_fix_dbz;

`ifdef MULDIV_UNSIGNED_EN
   assign w_in_uns = unsigned_op;
`else
   assign w_in_uns = 1'b0;
`endif

   assign w_a_neg = ~w_in_uns & a[WIDTH-1];
   assign w_b_neg = ~w_in_uns & b[WIDTH-1];
   assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
   assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_op  (r_op),
      .i_acc (r_acc),
      .i_q   (r_q),
      .i_q_1 (r_q_1),
      .i_m   (r_m),
      .o_acc (w_step_acc),
      .o_q   (w_step_q),
      .o_q_1 (w_step_q_1)
   );

   always_ff @(posedge clk) begin
      if (clr) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: if (start) w_state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (r_count == c_LAST) w_state_nxt = FIX;
         end
         FIX: begin
            busy        = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Final restore and sign fix-up; the MUL hi word adds a back in when an
   // unsigned multiplier was seen by Booth as negative.
   always_comb begin
      w_rem     = r_acc[WIDTH] ? (r_acc[WIDTH-1:0] + r_m[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      w_fix_dbz = 1'b0;
      w_fix_hi  = '0;
      w_fix_lo  = '0;
      if (r_op == OP_MUL) begin
         w_fix_hi = r_acc[WIDTH-1:0] + ((r_uns && r_b[WIDTH-1]) ? r_a : '0);
         w_fix_lo = r_q;
      end else if (r_b == '0) begin
         w_fix_dbz = 1'b1;
         w_fix_hi  = r_a;
         w_fix_lo  = '1;
      end else begin
         w_fix_lo = (!r_uns && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? (~r_q + 1'b1) : r_q;
         w_fix_hi = (!r_uns && r_a[WIDTH-1]) ? (~w_rem + 1'b1) : w_rem;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_count <= '0;
         r_op    <= OP_MUL;
         r_uns   <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_q_1   <= 1'b0;
         r_m     <= '0;
         r_z_hi  <= '0;
         r_z_lo  <= '0;
         r_dbz   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_count <= '0;
                  r_op    <= op;
                  r_uns   <= w_in_uns;
                  r_a     <= a;
                  r_b     <= b;
                  r_acc   <= '0;
                  r_q_1   <= 1'b0;
                  if (op == OP_MUL) begin
                     r_q <= b;
                     r_m <= {w_a_neg, a};
                  end else begin
                     r_q <= w_a_mag;
                     r_m <= {1'b0, w_b_mag};
                  end
               end
            end
            RUN: begin
               r_count <= r_count + 1'b1;
               r_acc   <= w_step_acc;
               r_q     <= w_step_q;
               r_q_1   <= w_step_q_1;
            end
            FIX: begin
               r_z_hi <= w_fix_hi;
               r_z_lo <= w_fix_lo;
               r_dbz  <= w_fix_dbz;
            end
            default: ;
         endcase
      end
   end

   assign z_hi        = r_z_hi;
   assign z_lo        = r_z_lo;
   assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module  : tb_mul_div_unit
// Brief   : Directed self-checking bench for mul_div_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        start = 1'b0;
   logic        op = OP_MUL;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] z_hi;
   logic [31:0] z_lo;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   mul_div_unit #(
      .WIDTH (32)
   ) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .op          (op),
`ifdef MULDIV_UNSIGNED_EN
      .unsigned_op (1'b0),
`endif
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .z_hi        (z_hi),
      .z_lo        (z_lo)
   );

   // Start one operation and wait for done; lat is edges after capture, -1 on timeout.
   task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt);
      @(posedge clk); #1;
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_1234;
      lat  = -1;
      bcnt = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (done) begin
            lat = n;
            break;
         end
         if (busy) bcnt++;
         @(posedge clk);
      end
   endtask

   task automatic test_reset;
      clr = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else pass_cnt++;
      total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL reset dbz: got %b want 0", div_by_zero); else pass_cnt++;
      total_cnt++; if (z_hi !== 32'h0) $display("FAIL reset z_hi: got %h want 0", z_hi); else pass_cnt++;
      total_cnt++; if (z_lo !== 32'h0) $display("FAIL reset z_lo: got %h want 0", z_lo); else pass_cnt++;
      clr = 1'b0;
   endtask

   task automatic test_mul;
      int lat, bcnt;
      run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, lat, bcnt);
      total_cnt++; if (lat !== 33) $display("FAIL mul latency: got %0d want 33", lat); else pass_cnt++;
      total_cnt++; if (bcnt !== 33) $display("FAIL mul busy cycles: got %0d want 33", bcnt); else pass_cnt++;
      total_cnt++; if (z_hi !== 32'hFFFF_FFFF) $display("FAIL mul 7x-3 z_hi: got %h want ffffffff", z_hi); else pass_cnt++;
      total_cnt++; if (z_lo !== 32'hFFFF_FFEB) $display("FAIL mul 7x-3 z_lo: got %h want ffffffeb", z_lo); else pass_cnt++;
      total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL mul dbz: got %b want 0", div_by_zero); else pass_cnt++;
      @(posedge clk); @(negedge clk);
      total_cnt++; if (done !== 1'b0) $display("FAIL done pulse width: got %b want 0", done); else pass_cnt++;
      run_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
      total_cnt++; if (z_hi !== 32'h4000_0000) $display("FAIL mul minxmin z_hi: got %h want 40000000", z_hi); else pass_cnt++;
      total_cnt++; if (z_lo !== 32'h0) $display("FAIL mul minxmin z_lo: got %h want 0", z_lo); else pass_cnt++;
      run_op(OP_MUL, 32'h0, 32'h1234_5678, lat, bcnt);
      total_cnt++; if ({z_hi, z_lo} !== 64'h0) $display("FAIL mul zero: got %h want 0", {z_hi, z_lo}); else pass_cnt++;
      total_cnt++; if (lat !== 33) $display("FAIL mul zero latency: got %0d want 33", lat); else pass_cnt++;
   endtask

   task automatic test_div;
      int lat, bcnt;
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
      total_cnt++; if (z_lo !== 32'hFFFF_FFFD) $display("FAIL div -7/2 quot: got %h want fffffffd", z_lo); else pass_cnt++;
      total_cnt++; if (z_hi !== 32'hFFFF_FFFF) $display("FAIL div -7/2 rem: got %h want ffffffff", z_hi); else pass_cnt++;
      total_cnt++; if (lat !== 33) $display("FAIL div latency: got %0d want 33", lat); else pass_cnt++;
      run_op(OP_DIV, 32'd100, 32'd7, lat, bcnt);
      total_cnt++; if (z_lo !== 32'd14) $display("FAIL div 100/7 quot: got %h want 0000000e", z_lo); else pass_cnt++;
      total_cnt++; if (z_hi !== 32'd2) $display("FAIL div 100/7 rem: got %h want 00000002", z_hi); else pass_cnt++;
   endtask

   task automatic test_div_boundaries;
      int lat, bcnt;
      run_op(OP_DIV, 32'd5, 32'd0, lat, bcnt);
      total_cnt++; if (div_by_zero !== 1'b1) $display("FAIL div0 flag: got %b want 1", div_by_zero); else pass_cnt++;
      total_cnt++; if (z_lo !== 32'hFFFF_FFFF) $display("FAIL div0 z_lo: got %h want ffffffff", z_lo); else pass_cnt++;
      total_cnt++; if (z_hi !== 32'd5) $display("FAIL div0 z_hi: got %h want 00000005", z_hi); else pass_cnt++;
      total_cnt++; if (lat !== 33) $display("FAIL div0 latency: got %0d want 33", lat); else pass_cnt++;
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      total_cnt++; if (z_lo !== 32'h8000_0000) $display("FAIL div min/-1 quot: got %h want 80000000", z_lo); else pass_cnt++;
      total_cnt++; if (z_hi !== 32'h0) $display("FAIL div min/-1 rem: got %h want 0", z_hi); else pass_cnt++;
      total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL div min/-1 flag: got %b want 0", div_by_zero); else pass_cnt++;
   endtask

   task automatic test_clr_abort;
      int lat, bcnt, pulses;
      @(posedge clk); #1;
      op = OP_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL clr abort busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (z_hi !== 32'h0) $display("FAIL clr abort z_hi: got %h want 0", z_hi); else pass_cnt++;
      total_cnt++; if (z_lo !== 32'h0) $display("FAIL clr abort z_lo: got %h want 0", z_lo); else pass_cnt++;
      pulses = 0;
      for (int n = 0; n < 40; n++) begin
         if (done) pulses++;
         @(negedge clk);
      end
      total_cnt++; if (pulses !== 0) $display("FAIL clr abort done pulses: got %0d want 0", pulses); else pass_cnt++;
      run_op(OP_MUL, 32'd3, 32'd4, lat, bcnt);
      total_cnt++; if (z_lo !== 32'd12) $display("FAIL mul after clr z_lo: got %h want 0000000c", z_lo); else pass_cnt++;
   endtask

   task automatic test_ignore_start;
      int pulses, lat;
      @(posedge clk); #1;
      op = OP_MUL; a = 32'd2; b = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1 op = OP_DIV; a = 32'd9; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      pulses = 0;
      lat = -1;
      for (int n = 6; n < 60; n++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (lat < 0) lat = n;
         end
         @(posedge clk);
      end
      total_cnt++; if (pulses !== 1) $display("FAIL ignore start pulses: got %0d want 1", pulses); else pass_cnt++;
      total_cnt++; if (lat !== 33) $display("FAIL ignore start latency: got %0d want 33", lat); else pass_cnt++;
      total_cnt++; if (z_lo !== 32'd4) $display("FAIL ignore start z_lo: got %h want 00000004", z_lo); else pass_cnt++;
   endtask

   // start held through DONE must not capture until the edge that leaves IDLE again
   task automatic test_back_to_back;
      int lat, bcnt;
      run_op(OP_MUL, 32'd2, 32'd3, lat, bcnt);
      op = OP_MUL; a = 32'd6; b = 32'd7; start = 1'b1;
      lat = -1;
      for (int n = 1; n < 80; n++) begin
         @(posedge clk);
         if (n == 2) begin
            #1 start = 1'b0;
         end
         @(negedge clk);
         if (done) begin
            lat = n;
            break;
         end
      end
      total_cnt++; if (lat !== 35) $display("FAIL back-to-back latency: got %0d want 35", lat); else pass_cnt++;
      total_cnt++; if (z_lo !== 32'd42) $display("FAIL back-to-back z_lo: got %h want 0000002a", z_lo); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_boundaries();
      test_clr_abort();
      test_ignore_start();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
